// File: rtl/pc_unit_if.sv
// Fetch-stage program-counter bus: request lines from the fetch
// controller and the PC/return-address-stack state reported back.
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             hit;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             trap;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next_seq;
    logic [WIDTH-1:0] ras_top;
    logic [CNT_W-1:0] ras_count;
    logic             ras_overflow;
    logic             ras_underflow;

    // Fetch controller side: issues requests, observes PC state.
    modport master (
        output hit, redirect_valid, redirect_target, call, ret, trap,
        input  pc, pc_next_seq, ras_top, ras_count, ras_overflow, ras_underflow
    );

    // PC unit side: consumes requests, drives PC state.
    modport slave (
        input  hit, redirect_valid, redirect_target, call, ret, trap,
        output pc, pc_next_seq, ras_top, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit with a circular return-address stack.
// State updates on the falling clock edge; reset is asynchronous active-low.
// Request priority: trap > stall (hit=0) > ret > redirect(+call) > advance.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h80),
    parameter int               RAS_DEPTH    = 4
) (
    input logic       clk,
    input logic       rst_n,
    pc_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = $clog2(RAS_DEPTH);

    localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(RAS_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(RAS_DEPTH - 1);

    // Architectural state
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [IDX_W-1:0] top_idx_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] ras_top_r;
    logic             overflow_r;
    logic             underflow_r;

    // Next-state decisions
    logic [WIDTH-1:0] seq_s;
    logic [WIDTH-1:0] pc_d_s;
    logic             push_s;
    logic             pop_s;
    logic             overflow_d_s;
    logic             underflow_d_s;
    logic             full_s;
    logic             empty_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic [IDX_W-1:0] idx_dec_s;

    // Sequential successor wraps modulo 2^WIDTH with no carry out.
    assign seq_s   = pc_r + STEP_C;
    assign full_s  = (count_r == FULL_C);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Circular neighbours of the top-of-stack slot (depth need not be a power of two).
    always_comb begin
        idx_inc_s = top_idx_r + IDX_W'(1);
        idx_dec_s = top_idx_r - IDX_W'(1);
        if (top_idx_r == LAST_IDX_C) begin
            idx_inc_s = {IDX_W{1'b0}};
        end else begin
            idx_inc_s = top_idx_r + IDX_W'(1);
        end
        if (top_idx_r == {IDX_W{1'b0}}) begin
            idx_dec_s = LAST_IDX_C;
        end else begin
            idx_dec_s = top_idx_r - IDX_W'(1);
        end
    end

    // Prioritised request decode: selects next PC and stack operation.
    always_comb begin
        pc_d_s        = pc_r;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        overflow_d_s  = overflow_r;
        underflow_d_s = underflow_r;
        if (bus.trap) begin
            pc_d_s = TRAP_VECTOR;
        end else if (!bus.hit) begin
            pc_d_s = pc_r;
        end else if (bus.ret) begin
            if (!empty_s) begin
                pc_d_s = ras_top_r;
                pop_s  = 1'b1;
            end else begin
                pc_d_s        = seq_s;
                underflow_d_s = 1'b1;
            end
        end else if (bus.redirect_valid) begin
            pc_d_s = bus.redirect_target;
            if (bus.call) begin
                push_s       = 1'b1;
                overflow_d_s = overflow_r | full_s;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            pc_d_s = seq_s;
        end
    end

    // PC, stack and sticky-flag registers, updated on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_VECTOR;
            top_idx_r   <= {IDX_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ras_top_r   <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pc_r        <= pc_d_s;
            overflow_r  <= overflow_d_s;
            underflow_r <= underflow_d_s;
            if (push_s) begin
                // On a full stack the slot after top is the oldest entry.
                ras_mem_r[idx_inc_s] <= seq_s;
                top_idx_r            <= idx_inc_s;
                ras_top_r            <= seq_s;
                if (!full_s) begin
                    count_r <= count_r + CNT_W'(1);
                end else begin
                    count_r <= count_r;
                end
            end else if (pop_s) begin
                top_idx_r <= idx_dec_s;
                count_r   <= count_r - CNT_W'(1);
                if (count_r == CNT_W'(1)) begin
                    ras_top_r <= {WIDTH{1'b0}};
                end else begin
                    ras_top_r <= ras_mem_r[idx_dec_s];
                end
            end else begin
                top_idx_r <= top_idx_r;
                count_r   <= count_r;
                ras_top_r <= ras_top_r;
            end
        end
    end

    assign bus.pc            = pc_r;
    assign bus.pc_next_seq   = seq_s;
    assign bus.ras_top       = ras_top_r;
    assign bus.ras_count     = count_r;
    assign bus.ras_overflow  = overflow_r;
    assign bus.ras_underflow = underflow_r;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// requests, all compared against a queue-based reference model.
module tb_pc_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(32'h80), .RAS_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: PC plus a bounded LIFO of return addresses.
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf;
    logic        m_unf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge();
        if (bus.trap) begin
            m_pc = 32'h80;
        end else if (!bus.hit) begin
            m_pc = m_pc;
        end else if (bus.ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = m_pc + 32'd4;
                m_unf = 1'b1;
            end
        end else if (bus.redirect_valid) begin
            if (bus.call) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
            end
            m_pc = bus.redirect_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        check({tag, ".pc"},        bus.pc, m_pc);
        check({tag, ".pc_seq"},    bus.pc_next_seq, m_pc + 32'd4);
        check({tag, ".ras_top"},   bus.ras_top, exp_top);
        check({tag, ".ras_count"}, 32'(bus.ras_count), 32'(m_ras.size()));
        check({tag, ".ovf"},       {31'b0, bus.ras_overflow}, {31'b0, m_ovf});
        check({tag, ".unf"},       {31'b0, bus.ras_underflow}, {31'b0, m_unf});
    endtask

    task automatic drive(input logic tr, input logic h, input logic r,
                         input logic rv, input logic [31:0] tg, input logic c);
        bus.trap            = tr;
        bus.hit             = h;
        bus.ret             = r;
        bus.redirect_valid  = rv;
        bus.redirect_target = tg;
        bus.call            = c;
    endtask

    // One falling edge with the currently driven request, then compare.
    task automatic step(input string tag);
        @(negedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Reset release then three advances
        step("adv1");
        step("adv2");
        step("adv3");
        check("adv3_const", bus.pc, 32'd12);

        // Stall holds a pending redirect until hit
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0); step("to_0x10");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0); step("stall1");
        step("stall2");
        check("stall_const", bus.pc, 32'h10);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); step("unstall");
        check("unstall_const", bus.pc, 32'h200);

        // Call and return
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0); step("to_0x40");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1); step("call");
        check("call_top_const", bus.ras_top, 32'h44);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step("plain1");
        step("plain2");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0); step("ret");
        check("ret_const", bus.pc, 32'h44);

        // Overflow: five calls into a four-deep stack
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0); step("to_0x0");
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'(i * 16), 1'b1);
            step("ovf_call");
        end
        check("ovf_count_const", 32'(bus.ras_count), 32'd4);
        check("ovf_flag_const", {31'b0, bus.ras_overflow}, 32'd1);

        // Underflow: five returns
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step("ret1"); check("ret1_const", bus.pc, 32'h44);
        step("ret2"); check("ret2_const", bus.pc, 32'h34);
        step("ret3"); check("ret3_const", bus.pc, 32'h24);
        step("ret4"); check("ret4_const", bus.pc, 32'h14);
        step("ret5"); check("ret5_const", bus.pc, 32'h18);
        check("unf_flag_const", {31'b0, bus.ras_underflow}, 32'd1);

        // Trap outranks stall and ret; stack untouched
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1); step("pre_trap_call");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step("trap");
        check("trap_const", bus.pc, 32'h80);
        check("trap_top_const", bus.ras_top, 32'h1c);

        // Wrap at the top of the address space
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0); step("to_top");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step("wrap");
        check("wrap_const", bus.pc, 32'h0);

        // Asynchronous reset pulse between edges
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1); step("pre_reset_call");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        check("async_reset_const", bus.pc, 32'h0);
        #1 rst_n = 1'b1;

        // Random requests against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  $urandom(), $urandom_range(0, 1) == 1);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage, successor to the single-register PC. Holds the PC, advances it by a fixed step on each fetch hit, stalls on a miss, and accepts branch redirects and trap vectoring. Also keeps a small return-address stack (RAS) so call/return pairs redirect without an external target.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits
- STEP, 4, sequential increment added per advance
- RESET_VECTOR, 0, PC value while and after reset
- TRAP_VECTOR, 32'h80, PC loaded on trap
- RAS_DEPTH, 4, return-address stack entries (≥2)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  asynchronous, active-low reset
- hit  in  1  1 = fetch hit, PC may change; 0 = stall
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  WIDTH  target for redirect_valid
- call  in  1  qualifies redirect_valid: push return address
- ret  in  1  return: pop RAS into PC
- trap  in  1  vector to TRAP_VECTOR
- pc  out  WIDTH  current PC (registered)
- pc_next_seq  out  WIDTH  combinational pc + STEP
- ras_top  out  WIDTH  current top entry (0 when empty)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid entries
- ras_overflow  out  1  sticky: push onto full stack
- ras_underflow  out  1  sticky: ret on empty stack

## Operation
- Reset (rst_n=0, immediate): pc=RESET_VECTOR, ras_count=0, ras_top=0, both flags 0. RAS storage contents don't care.
- Per falling edge, first matching rule applies:
  1. trap=1: pc←TRAP_VECTOR, regardless of hit. RAS and flags unchanged; call/ret/redirect ignored.
  2. hit=0: hold pc, RAS, and flags. All other requests are ignored; the requester keeps them asserted until hit.
  3. ret=1: if ras_count>0, pc←ras_top, pop. If empty, pc←pc+STEP and ras_underflow←1. A simultaneous call or redirect_valid is ignored.
  4. redirect_valid=1: pc←redirect_target. If call=1, also push pc+STEP.
  5. Otherwise pc←pc+STEP. A call without redirect_valid is ignored.
- Push on full stack (ras_count=RAS_DEPTH): the oldest entry is overwritten (circular), ras_count stays at RAS_DEPTH, and ras_overflow←1.
- Arithmetic: pc+STEP is modulo 2^WIDTH, so all-ones minus STEP+1 wraps to low addresses; no carry is flagged. The pushed value uses the same wrap.
- redirect_target is loaded unmodified; alignment checking is the decoder's responsibility.
- Sticky flags clear only on reset.

## Timing
- pc, ras_top, ras_count, and the flags change only on a falling clk edge or on asynchronous reset assertion.
- Latency:
  - Request sampled at falling edge N, so the new pc is visible right after N.
  - A pushed address appears on ras_top after the same edge.
- Back-to-back call then ret on consecutive hit edges returns to the call site + STEP.
- Reset deassertion is not synchronised internally. The first update is the first falling edge with rst_n=1, and it applies the normal rules (with hit=1, pc becomes RESET_VECTOR+STEP).
- Reset asserted mid-stall or mid-call sequence discards all pending state.
- pc_next_seq is combinational from pc only.

## Test plan
- Reset and advance: rst_n=0, then release with hit=1 for 3 falling edges -> pc 0→4→8→12; ras_count=0; flags 0.
- Stall: at pc=0x10 hold hit=0 with redirect_valid=1 and target 0x200 for 2 edges -> pc stays 0x10. Raise hit -> pc=0x200.
- Call/return: at pc=0x40, redirect 0x100 with call -> pc=0x100, ras_top=0x44, count=1. Two plain advances, then ret -> pc=0x44, count=0.
- Overflow/underflow: with RAS_DEPTH=4 do 5 calls from pcs 0x0,0x10,0x20,0x30,0x40 -> count=4, ras_overflow=1. Then 5 rets -> pcs 0x44,0x34,0x24,0x14, then pc+4 with ras_underflow=1.
- Priority and wrap:
  - trap with hit=0 and ret=1 -> pc=0x80, RAS unchanged.
  - pc=0xFFFFFFFC with hit -> pc=0x00000000.
  - Async reset pulse mid-cycle -> pc=0 immediately, count=0.
